wb_led_arbiter: RTL and testbench
=================================

# wb_led_arbiter

Wishbone-slave controller in the user project area that owns the 8 LED pins (mprj_io[18:11]) and arbitrates them between two requesters: firmware writes over Wishbone and a hardware pattern engine driven by the 3 debounced buttons (mprj_io[10:8]). A mode register selects fixed CPU ownership, fixed button ownership, or automatic hand-over, where button activity takes the LEDs for a programmable hold time.

## Interface
- BASE_ADDR, 32'h3000_0000, base address; decode compares wb_adr_i[31:4] to BASE_ADDR[31:4]
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before the debounced level changes; legal range 1..65535
- wb_clk_i  in  1  system clock
- wb_rst_n_i  in  1  asynchronous active-low reset
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  write enable
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- buttons  in  3  raw, asynchronous button inputs
- leds  out  8  LED drive
- leds_oeb  out  8  output-enable, active-low; constant 8'h00 after reset release
- irq  out  1  button-event interrupt; present only with WB_LED_ARB_IRQ_EN

## Operation
- Registers, word offsets; sel ignored; full-word access:
  - 0x0 CTRL rw: [1:0] mode. 0 = CPU, 1 = BTN, 2 = AUTO, 3 = treated as CPU.
  - 0x4 LED_CPU rw: [7:0] CPU LED value.
  - 0x8 STATUS ro: [0] owner (1 = BTN); [3:1] debounced buttons; [15:8] current leds; [16] irq pending. Writing 1 to [16] clears pending.
  - 0xC HOLD rw: [15:0] AUTO hold length in cycles.
- Debounce per button: 2-flop synchronizer, then a counter. The debounced level flips after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles. Any agreeing cycle clears the counter.
- Pattern engine, register pat[7:0], on debounced rising edges. Priority when edges coincide: btn2 (pat <= 0) > btn1 (rotate left by 1) > btn0 (pat <= pat + 1, wraps at 8'hFF).
- Arbiter FSM, states CPU_OWN and BTN_OWN:
  - Mode CPU: always CPU_OWN.
  - Mode BTN: always BTN_OWN.
  - Mode AUTO: in CPU_OWN, any rising edge with HOLD != 0 moves to BTN_OWN and loads hold_cnt = HOLD. In BTN_OWN, hold_cnt decrements each cycle; when it would reach 0 the FSM returns to CPU_OWN. A new edge reloads HOLD. With HOLD = 0, AUTO stays in CPU_OWN, but pat still updates.
  - Any CTRL write forces CPU_OWN and hold_cnt = 0 for one cycle, then the new mode applies.
- leds = registered (owner ? pat : LED_CPU).
- Reset values: CTRL 0, LED_CPU 0, HOLD 0, pat 0, owner CPU_OWN, debounced levels 0, leds 8'h00, leds_oeb 8'hFF, wbs_ack_o 0, wbs_dat_o 0, irq 0. Reset mid-transfer drops ack immediately. Reset mid-hold returns the FSM to CPU_OWN.
- Unmapped offsets inside the 16-byte window are acked; reads return 0; writes are ignored. Out-of-window addresses are never acked.

## Timing
- Wishbone: ack asserts 1 cycle after cyc&stb&!ack and stays high for exactly 1 cycle. Read data is valid with ack. A write takes effect on the ack edge. Back-to-back accesses need a new stb.
- leds_oeb: goes to 8'h00 on the first clock after reset release.
- Button to debounced level: 2 + DEBOUNCE_CYCLES cycles.
- Debounced edge to pat update: 1 cycle. pat/owner to leds: 1 cycle.
- LED_CPU write to leds: 1 cycle after ack, when owner is CPU.
- AUTO hold: BTN_OWN lasts exactly HOLD cycles after the last edge.

## Configuration
- WB_LED_ARB_IRQ_EN defined:
  - irq port exists.
  - STATUS[16] sets on any debounced rising edge and clears on a write of 1. Set wins over a same-cycle clear.
  - irq = STATUS[16], registered.
- Not defined: no irq port; STATUS[16] reads 0; the clear write is ignored.

## Test plan
- Reset: leds = 0, leds_oeb = FF, ack = 0, STATUS reads 0. After release, leds_oeb = 00.
- Mode CPU: write LED_CPU = 0xA5 -> leds = 0xA5 one cycle after ack; STATUS[15:8] = 0xA5.
- Mode BTN, DEBOUNCE_CYCLES = 16:
  - 3 presses of btn0, each held 40 cycles -> leds = 0x03.
  - Then a btn1 press -> 0x06.
  - A 10-cycle glitch -> no change.
  - All 3 buttons pressed together -> leds = 0x00.
- Mode AUTO, HOLD = 100, LED_CPU = 0x0F:
  - btn0 press -> leds = pat, owner = 1 for 100 cycles, then leds = 0x0F.
  - A second press at cycle 50 extends ownership to 150 cycles.
- AUTO with HOLD = 0: btn0 press -> leds stay 0x0F, and STATUS shows the pattern was incremented.
- With WB_LED_ARB_IRQ_EN: a btn2 press sets irq. Write STATUS[16] = 1 -> irq = 0 the next cycle. A press coinciding with the clear leaves irq = 1.

Source files
------------

// File: rtl/wb_led_arbiter.sv
// ---------------------------------------------------------------------------
// wb_led_arbiter
//
// Wishbone slave that owns the 8 LED pins and shares them between firmware
// (LED_CPU register) and a button-driven pattern engine. A mode register
// selects fixed CPU ownership, fixed button ownership, or automatic hand-over
// where a debounced button press takes the LEDs for HOLD cycles.
//
// Optional feature macro: WB_LED_ARB_IRQ_EN (adds the irq port and the
// STATUS[16] pending bit; without it STATUS[16] reads 0).
//
// Ports
//   wb_clk_i, wb_rst_n_i   clock, asynchronous active-low reset
//   wbs_cyc_i/stb_i/we_i   Wishbone control
//   wbs_adr_i, wbs_dat_i   byte address, write data
//   wbs_ack_o, wbs_dat_o   acknowledge, read data
//   buttons[2:0]           raw asynchronous buttons
//   leds[7:0]              LED drive
//   leds_oeb[7:0]          output enable, active low
//   irq                    button-event interrupt (WB_LED_ARB_IRQ_EN only)
//
// Register map (word offsets, byte offset bits [1:0] must be 0)
//   0x0 CTRL    [1:0] mode: 0 CPU, 1 BTN, 2 AUTO, 3 CPU
//   0x4 LED_CPU [7:0]
//   0x8 STATUS  [0] owner, [3:1] debounced buttons, [15:8] leds, [16] pending
//   0xC HOLD    [15:0] AUTO hold length in cycles
//
// Arbiter FSM
//   state   | meaning
//   CPU_OWN | leds driven from LED_CPU
//   BTN_OWN | leds driven from pattern register
// ---------------------------------------------------------------------------
module wb_led_arbiter #(
    parameter logic [31:0] BASE_ADDR       = 32'h3000_0000,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic [2:0]  buttons,
    output logic [7:0]  leds,
    output logic [7:0]  leds_oeb
`ifdef WB_LED_ARB_IRQ_EN
    ,
    output logic        irq
`endif
);

    typedef enum logic {
        CPU_OWN = 1'b0,
        BTN_OWN = 1'b1
    } state_t;

    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [1:0]  r_ctrl;
    logic [7:0]  r_led_cpu;
    logic [15:0] r_hold;
    logic [7:0]  r_pat;
    state_t      r_state;
    logic [15:0] r_hold_cnt;
    logic [7:0]  r_leds;
    logic [7:0]  r_oeb;
    logic        r_ack;
    logic [31:0] r_dat;
    logic [2:0]  r_sync1;
    logic [2:0]  r_sync2;
    logic [2:0]  r_db;
    logic [2:0]  r_db_d;
    logic [15:0] r_db_cnt [3];

    logic        w_hit;
    logic        w_acc;
    logic        w_wr;
    logic        w_reg_ok;
    logic [1:0]  w_off;
    logic        w_ctrl_wr;
    logic        w_pend_clr;
    logic        w_pend;
    logic [2:0]  w_rise;
    logic        w_any_rise;
    logic [31:0] w_rdata;
    logic        w_unused;

    // ------------------------------------------------------------------
    // Wishbone decode
    // ------------------------------------------------------------------
    assign w_hit      = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign w_acc      = wbs_cyc_i & wbs_stb_i & ~r_ack & w_hit;
    assign w_wr       = w_acc & wbs_we_i;
    // Non-word-aligned offsets are treated as unmapped: acked, read 0.
    assign w_reg_ok   = (wbs_adr_i[1:0] == 2'b00);
    assign w_off      = wbs_adr_i[3:2];
    assign w_ctrl_wr  = w_wr & w_reg_ok & (w_off == 2'd0);
    assign w_pend_clr = w_wr & w_reg_ok & (w_off == 2'd2) & wbs_dat_i[16];

    assign w_rise     = r_db & ~r_db_d;
    assign w_any_rise = |w_rise;

    assign w_unused   = &{1'b0, wbs_dat_i};

    always_comb begin
        w_rdata = 32'h0;
        if (w_reg_ok) begin
            case (w_off)
                2'd0: w_rdata = {30'h0, r_ctrl};
                2'd1: w_rdata = {24'h0, r_led_cpu};
                2'd2: w_rdata = {15'h0, w_pend, r_leds, 4'h0, r_db, r_state == BTN_OWN};
                default: w_rdata = {16'h0, r_hold};
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_ack     <= 1'b0;
            r_dat     <= 32'h0;
            r_ctrl    <= 2'd0;
            r_led_cpu <= 8'h00;
            r_hold    <= 16'h0;
        end else begin
            r_ack <= w_acc;
            r_dat <= w_acc ? w_rdata : 32'h0;
            if (w_wr && w_reg_ok) begin
                case (w_off)
                    2'd0: r_ctrl    <= wbs_dat_i[1:0];
                    2'd1: r_led_cpu <= wbs_dat_i[7:0];
                    2'd3: r_hold    <= wbs_dat_i[15:0];
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Button synchronizer and debounce
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
            r_db    <= 3'b000;
            r_db_d  <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                r_db_cnt[i] <= 16'h0;
            end
        end else begin
            r_sync1 <= buttons;
            r_sync2 <= r_sync1;
            r_db_d  <= r_db;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] != r_db[i]) begin
                    if (r_db_cnt[i] == DB_LAST) begin
                        r_db[i]     <= r_sync2[i];
                        r_db_cnt[i] <= 16'h0;
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + 16'h1;
                    end
                end else begin
                    r_db_cnt[i] <= 16'h0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Pattern engine: btn2 clear > btn1 rotate > btn0 increment
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_pat <= 8'h00;
        end else if (w_rise[2]) begin
            r_pat <= 8'h00;
        end else if (w_rise[1]) begin
            r_pat <= {r_pat[6:0], r_pat[7]};
        end else if (w_rise[0]) begin
            r_pat <= r_pat + 8'h01;
        end
    end

    // ------------------------------------------------------------------
    // Arbiter FSM. A CTRL write parks the FSM in CPU_OWN for one cycle so
    // every mode change starts from a known owner with the timer cleared.
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state    <= CPU_OWN;
            r_hold_cnt <= 16'h0;
        end else if (w_ctrl_wr) begin
            r_state    <= CPU_OWN;
            r_hold_cnt <= 16'h0;
        end else begin
            case (r_ctrl)
                2'd1: begin
                    r_state    <= BTN_OWN;
                    r_hold_cnt <= 16'h0;
                end
                2'd2: begin
                    case (r_state)
                        CPU_OWN: begin
                            if (w_any_rise && (r_hold != 16'h0)) begin
                                r_state    <= BTN_OWN;
                                r_hold_cnt <= r_hold;
                            end
                        end
                        default: begin
                            if (w_any_rise && (r_hold != 16'h0)) begin
                                r_hold_cnt <= r_hold;
                            end else if (w_any_rise || (r_hold_cnt <= 16'h1)) begin
                                // Terminal count (or HOLD cleared while owned).
                                r_state    <= CPU_OWN;
                                r_hold_cnt <= 16'h0;
                            end else begin
                                r_hold_cnt <= r_hold_cnt - 16'h1;
                            end
                        end
                    endcase
                end
                default: begin
                    r_state    <= CPU_OWN;
                    r_hold_cnt <= 16'h0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // LED output stage
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_leds <= 8'h00;
            r_oeb  <= 8'hFF;
        end else begin
            r_leds <= (r_state == BTN_OWN) ? r_pat : r_led_cpu;
            r_oeb  <= 8'h00;
        end
    end

    // ------------------------------------------------------------------
    // Interrupt pending bit; a same-cycle edge beats the clear.
    // ------------------------------------------------------------------
`ifdef WB_LED_ARB_IRQ_EN
    logic r_pend;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_pend <= 1'b0;
        end else if (w_any_rise) begin
            r_pend <= 1'b1;
        end else if (w_pend_clr) begin
            r_pend <= 1'b0;
        end
    end

    assign w_pend = r_pend;
    assign irq    = r_pend;
`else
    assign w_pend = 1'b0;
`endif

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign leds      = r_leds;
    assign leds_oeb  = r_oeb;

endmodule

// File: tb/tb_wb_led_arbiter.sv
module tb_wb_led_arbiter;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h0;
    localparam logic [31:0] A_LED  = BASE + 32'h4;
    localparam logic [31:0] A_STAT = BASE + 32'h8;
    localparam logic [31:0] A_HOLD = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [31:0] adr = 32'h0;
    logic [31:0] wdat = 32'h0;
    logic        ack;
    logic [31:0] rdat;
    logic [2:0]  btn = 3'b000;
    logic [7:0]  leds;
    logic [7:0]  oeb;
`ifdef WB_LED_ARB_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_led_arbiter #(.BASE_ADDR(BASE), .DEBOUNCE_CYCLES(16)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_we_i   (we),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (wdat),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (rdat),
        .buttons    (btn),
        .leds       (leds),
        .leds_oeb   (oeb)
`ifdef WB_LED_ARB_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    // Bus tasks return at ack-edge + 1.
    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        int n;
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 1; adr = a; wdat = d;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ack && n < 8);
        checks++;
        if (!(ack === 1'b1 && n == 1)) begin
            errors++;
            $display("FAIL wr_ack addr=%h ack=%b after %0d cycles, want ack=1 after 1", a, ack, n);
        end
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        int n;
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 0; adr = a;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ack && n < 8);
        d = rdat;
        checks++;
        if (!(ack === 1'b1 && n == 1)) begin
            errors++;
            $display("FAIL rd_ack addr=%h ack=%b after %0d cycles, want ack=1 after 1", a, ack, n);
        end
        cyc = 0; stb = 0;
    endtask

    task automatic press(input logic [2:0] m, input int hold);
        @(posedge clk); #1;
        btn = m;
        repeat (hold) @(posedge clk);
        #1 btn = 3'b000;
        repeat (30) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        #12;
        checks++;
        if (leds !== 8'h00 || oeb !== 8'hFF || ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs leds=%h oeb=%h ack=%b want 00 FF 0", leds, oeb, ack);
        end
        @(posedge clk); #1;
        rst_n = 1;
        checks++;
        if (oeb !== 8'hFF) begin
            errors++;
            $display("FAIL oeb_before_edge got %h want FF", oeb);
        end
        @(posedge clk); #1;
        checks++;
        if (oeb !== 8'h00) begin
            errors++;
            $display("FAIL oeb_after_release got %h want 00", oeb);
        end
        wb_read(A_STAT, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL reset_status got %h want 0", d);
        end
    endtask

    task automatic test_cpu();
        logic [31:0] d;
        wb_write(A_LED, 32'h0000_00A5);
        checks++;
        if (leds !== 8'h00) begin
            errors++;
            $display("FAIL cpu_led_early got %h want 00", leds);
        end
        @(posedge clk); #1;
        checks++;
        if (leds !== 8'hA5) begin
            errors++;
            $display("FAIL cpu_led got %h want A5", leds);
        end
        wb_read(A_STAT, d);
        checks++;
        if ((d & 32'hFFFF) !== 32'hA500) begin
            errors++;
            $display("FAIL cpu_status got %h want A500", d);
        end
        wb_read(A_LED, d);
        checks++;
        if (d !== 32'hA5) begin
            errors++;
            $display("FAIL led_cpu_readback got %h want A5", d);
        end
    endtask

    task automatic test_window();
        logic [31:0] d;
        int seen;
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 1; adr = BASE + 32'h10; wdat = 32'h0000_0033;
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (ack) seen++;
        end
        cyc = 0; stb = 0; we = 0;
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL out_of_window acks=%0d want 0", seen);
        end
        wb_write(BASE + 32'h5, 32'h0000_00FF);
        wb_read(A_LED, d);
        checks++;
        if (d !== 32'hA5) begin
            errors++;
            $display("FAIL unmapped_write_effect got %h want A5", d);
        end
        wb_read(BASE + 32'h5, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_read got %h want 0", d);
        end
    endtask

    task automatic test_btn();
        logic [31:0] d;
        wb_write(A_CTRL, 32'h1);
        @(posedge clk); #1;
        btn = 3'b001;
        repeat (19) @(posedge clk);
        #1;
        checks++;
        if (leds !== 8'h00) begin
            errors++;
            $display("FAIL debounce_latency_early got %h want 00", leds);
        end
        @(posedge clk); #1;
        checks++;
        if (leds !== 8'h01) begin
            errors++;
            $display("FAIL debounce_latency got %h want 01", leds);
        end
        repeat (20) @(posedge clk);
        #1 btn = 3'b000;
        repeat (30) @(posedge clk);
        press(3'b001, 40);
        press(3'b001, 40);
        checks++;
        if (leds !== 8'h03) begin
            errors++;
            $display("FAIL btn0_x3 got %h want 03", leds);
        end
        press(3'b010, 40);
        checks++;
        if (leds !== 8'h06) begin
            errors++;
            $display("FAIL btn1_rotate got %h want 06", leds);
        end
        press(3'b001, 10);
        checks++;
        if (leds !== 8'h06) begin
            errors++;
            $display("FAIL glitch got %h want 06", leds);
        end
        wb_read(A_STAT, d);
        checks++;
        if ((d & 32'hFFFF) !== 32'h0601) begin
            errors++;
            $display("FAIL btn_status got %h want 0601", d);
        end
        press(3'b111, 40);
        checks++;
        if (leds !== 8'h00) begin
            errors++;
            $display("FAIL all_buttons got %h want 00", leds);
        end
    endtask

    task automatic test_ctrl_force();
        logic [31:0] d;
        wb_write(A_CTRL, 32'h1);
        checks++;
        if (leds !== 8'h00) begin
            errors++;
            $display("FAIL force_t0 got %h want 00", leds);
        end
        @(posedge clk); #1;
        checks++;
        if (leds !== 8'hA5) begin
            errors++;
            $display("FAIL force_cpu_cycle got %h want A5", leds);
        end
        @(posedge clk); #1;
        checks++;
        if (leds !== 8'h00) begin
            errors++;
            $display("FAIL force_btn_again got %h want 00", leds);
        end
        wb_write(A_CTRL, 32'h3);
        repeat (3) @(posedge clk);
        #1;
        wb_read(A_STAT, d);
        checks++;
        if ((d & 32'hFFFF) !== 32'hA500) begin
            errors++;
            $display("FAIL mode3_status got %h want A500", d);
        end
    endtask

    task automatic test_auto();
        logic [31:0] d;
        wb_write(A_HOLD, 32'h1234_0064);
        wb_read(A_HOLD, d);
        checks++;
        if (d !== 32'h64) begin
            errors++;
            $display("FAIL hold_readback got %h want 64", d);
        end
        wb_write(A_LED, 32'h0F);
        wb_write(A_CTRL, 32'h2);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (leds !== 8'h0F) begin
            errors++;
            $display("FAIL auto_idle got %h want 0F", leds);
        end
        // Single press: 100-cycle ownership.
        @(posedge clk); #1;
        btn = 3'b001;
        for (int c = 1; c <= 125; c++) begin
            @(posedge clk); #1;
            if (c == 20) btn = 3'b000;
            if (c == 20 || c == 119) begin
                checks++;
                if (leds !== 8'h01) begin
                    errors++;
                    $display("FAIL auto_hold c=%0d got %h want 01", c, leds);
                end
            end
            if (c == 120) begin
                checks++;
                if (leds !== 8'h0F) begin
                    errors++;
                    $display("FAIL auto_release got %h want 0F", leds);
                end
            end
        end
        // Second press at cycle 50 extends ownership to 150 cycles.
        @(posedge clk); #1;
        btn = 3'b001;
        for (int c = 1; c <= 175; c++) begin
            @(posedge clk); #1;
            if (c == 20 || c == 70) btn = 3'b000;
            if (c == 50) btn = 3'b001;
            if (c == 20) begin
                checks++;
                if (leds !== 8'h02) begin
                    errors++;
                    $display("FAIL auto2_first got %h want 02", leds);
                end
            end
            if (c == 70 || c == 120 || c == 169) begin
                checks++;
                if (leds !== 8'h03) begin
                    errors++;
                    $display("FAIL auto2_extend c=%0d got %h want 03", c, leds);
                end
            end
            if (c == 170) begin
                checks++;
                if (leds !== 8'h0F) begin
                    errors++;
                    $display("FAIL auto2_release got %h want 0F", leds);
                end
            end
        end
    endtask

    task automatic test_auto_hold0();
        logic [31:0] d;
        int bad;
        wb_write(A_HOLD, 32'h0);
        @(posedge clk); #1;
        btn = 3'b001;
        bad = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (c == 25) btn = 3'b000;
            if (leds !== 8'h0F) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold0_leds cycles_wrong=%0d want 0", bad);
        end
        wb_read(A_STAT, d);
        checks++;
        if ((d & 32'hFFFF) !== 32'h0F00) begin
            errors++;
            $display("FAIL hold0_status got %h want 0F00", d);
        end
        wb_write(A_CTRL, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        wb_read(A_STAT, d);
        checks++;
        if ((d & 32'hFFFF) !== 32'h0401) begin
            errors++;
            $display("FAIL hold0_pattern got %h want 0401", d);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 0; adr = A_LED;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ack && n < 8);
        checks++;
        if (ack !== 1'b1 || rdat !== 32'h0F) begin
            errors++;
            $display("FAIL b2b_first ack=%b data=%h want 1 0F", ack, rdat);
        end
        @(posedge clk); #1;
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL ack_one_cycle ack=%b want 0", ack);
        end
        cyc = 0; stb = 0;
    endtask

    task automatic test_irq();
        logic [31:0] d;
`ifdef WB_LED_ARB_IRQ_EN
        wb_write(A_CTRL, 32'h0);
        wb_write(A_STAT, 32'h0001_0000);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_initial_clear got %b want 0", irq);
        end
        press(3'b100, 40);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set got %b want 1", irq);
        end
        wb_read(A_STAT, d);
        checks++;
        if (d[16] !== 1'b1) begin
            errors++;
            $display("FAIL irq_status got %b want 1", d[16]);
        end
        wb_write(A_STAT, 32'h0001_0000);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear got %b want 0", irq);
        end
        @(posedge clk); #1;
        btn = 3'b100;
        repeat (18) @(posedge clk);
        #1;
        cyc = 1; stb = 1; we = 1; adr = A_STAT; wdat = 32'h0001_0000;
        @(posedge clk); #1;
        checks++;
        if (ack !== 1'b1 || irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set_wins ack=%b irq=%b want 1 1", ack, irq);
        end
        cyc = 0; stb = 0; we = 0;
        repeat (25) @(posedge clk);
        #1 btn = 3'b000;
        repeat (30) @(posedge clk);
`else
        press(3'b100, 40);
        wb_write(A_STAT, 32'h0001_0000);
        wb_read(A_STAT, d);
        checks++;
        if (d[16] !== 1'b0) begin
            errors++;
            $display("FAIL status16_no_irq got %b want 0", d[16]);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        wb_write(A_HOLD, 32'd100);
        wb_write(A_CTRL, 32'h2);
        @(posedge clk); #1;
        btn = 3'b001;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (c == 20) btn = 3'b000;
        end
        checks++;
        if (leds !== 8'h01) begin
            errors++;
            $display("FAIL mid_hold_owner got %h want 01", leds);
        end
        cyc = 1; stb = 1; we = 1; adr = A_LED; wdat = 32'h55;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        checks++;
        if (ack !== 1'b0 || leds !== 8'h00 || oeb !== 8'hFF) begin
            errors++;
            $display("FAIL reset_mid ack=%b leds=%h oeb=%h want 0 00 FF", ack, leds, oeb);
        end
        cyc = 0; stb = 0; we = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        repeat (3) @(posedge clk);
        #1;
        wb_read(A_STAT, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_status got %h want 0", d);
        end
        wb_read(A_HOLD, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_hold got %h want 0", d);
        end
    endtask

    initial begin
        test_reset();
        test_cpu();
        test_window();
        test_btn();
        test_ctrl_force();
        test_auto();
        test_auto_hold0();
        test_back_to_back();
        test_irq();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
